// File: rtl/swizzle_pkg.sv
// Shared swizzle geometry and the load-sequencer state encoding.
package swizzle_pkg;

    localparam int MEM_CTRL_DWIDTH         = 40;
    localparam int RAM_PORT_AWIDTH         = 9;
    localparam int RAM_NUM_WORDS           = 512;
    // Input words the swizzle collects before swapping its transpose buffers.
    localparam int COUNT_TO_SWITCH_BUFFERS = MEM_CTRL_DWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } load_state_t;

endpackage

// File: rtl/swizzle_rd_credit.sv
// Read-request issue under a credit limit: tracks issued, received and in-flight words.
module swizzle_rd_credit #(
    parameter int DRAM_AWIDTH     = 32,
    parameter int COUNT_WIDTH     = 25,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [DRAM_AWIDTH-1:0] base,
    input  logic [COUNT_WIDTH-1:0] total,
    input  logic                   enable,
    input  logic                   req_ready,
    input  logic                   resp_accept,
    output logic                   req_valid,
    output logic [DRAM_AWIDTH-1:0] req_addr,
    output logic                   all_received
);

    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

    logic [DRAM_AWIDTH-1:0] base_q;
    logic [COUNT_WIDTH-1:0] total_q;
    logic [COUNT_WIDTH-1:0] issued_q;
    logic [COUNT_WIDTH-1:0] received_q;
    logic [OUT_WIDTH-1:0]   outstanding_q;
    logic                   req_fire;

    // Valid only depends on registered state, so it cannot drop while waiting for ready.
    assign req_valid    = enable && (issued_q < total_q) &&
                          (outstanding_q < OUT_WIDTH'(MAX_OUTSTANDING));
    assign req_fire     = req_valid && req_ready;
    assign req_addr     = base_q + DRAM_AWIDTH'(issued_q);
    assign all_received = (received_q == total_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q        <= '0;
            total_q       <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
        end else if (load) begin
            base_q        <= base;
            total_q       <= total;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
        end else begin
            if (req_fire) begin
                issued_q <= issued_q + COUNT_WIDTH'(1);
            end
            if (resp_accept) begin
                received_q <= received_q + COUNT_WIDTH'(1);
            end
            case ({req_fire, resp_accept})
                2'b10:   outstanding_q <= outstanding_q + OUT_WIDTH'(1);
                2'b01:   outstanding_q <= outstanding_q - OUT_WIDTH'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: rtl/swizzle_load_ctrl.sv
// Load sequencer for swizzle_dram_to_cram: issues DRAM reads, streams data, waits for the last RAM write.
module swizzle_load_ctrl #(
    parameter int DRAM_AWIDTH     = 32,
    parameter int MEM_CTRL_DWIDTH = 40,
    parameter int RAM_PORT_AWIDTH = 9,
    parameter int RAM_NUM_WORDS   = 512,
    parameter int NUM_RAMS_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DRAIN_TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DRAM_AWIDTH-1:0]     cmd_dram_base,
    input  logic [NUM_RAMS_WIDTH-1:0]  cmd_num_rams,
    output logic                       rd_req_valid,
    input  logic                       rd_req_ready,
    output logic [DRAM_AWIDTH-1:0]     rd_req_addr,
    input  logic                       rd_resp_valid,
    input  logic [MEM_CTRL_DWIDTH-1:0] rd_resp_data,
    output logic                       swz_resetn,
    output logic                       swz_data_valid,
    output logic [MEM_CTRL_DWIDTH-1:0] swz_data,
    input  logic                       swz_ram_we,
    input  logic [RAM_PORT_AWIDTH-1:0] swz_ram_addr,
    input  logic [NUM_RAMS_WIDTH-1:0]  swz_ram_num,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    import swizzle_pkg::*;

    localparam int TOTAL_WIDTH     = NUM_RAMS_WIDTH + RAM_PORT_AWIDTH;
    localparam int DRAIN_CNT_WIDTH = $clog2(DRAIN_TIMEOUT + 1);

    load_state_t                state_q;
    load_state_t                state_d;
    logic [NUM_RAMS_WIDTH-1:0]  num_rams_q;
    logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_q;
    logic [TOTAL_WIDTH-1:0]     cmd_total;
    logic                       accept;
    logic                       all_received;
    logic                       resp_accept;
    logic                       resp_spurious;
    logic                       last_write;
    logic                       drain_timeout;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_total = TOTAL_WIDTH'(cmd_num_rams) * TOTAL_WIDTH'(RAM_NUM_WORDS);

    // Data is only forwarded while a command still expects words; anything else is an error.
    assign resp_accept   = rd_resp_valid && busy && !all_received;
    assign resp_spurious = rd_resp_valid && !resp_accept;

    assign last_write    = swz_ram_we &&
                           (swz_ram_addr == RAM_PORT_AWIDTH'(RAM_NUM_WORDS - 1)) &&
                           (swz_ram_num == num_rams_q - NUM_RAMS_WIDTH'(1));
    assign drain_timeout = (drain_cnt_q == DRAIN_CNT_WIDTH'(DRAIN_TIMEOUT - 1));

    swizzle_rd_credit #(
        .DRAM_AWIDTH     (DRAM_AWIDTH),
        .COUNT_WIDTH     (TOTAL_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk          (clk),
        .resetn       (resetn),
        .load         (accept),
        .base         (cmd_dram_base),
        .total        (cmd_total),
        .enable       (state_q == ST_STREAM),
        .req_ready    (rd_req_ready),
        .resp_accept  (resp_accept),
        .req_valid    (rd_req_valid),
        .req_addr     (rd_req_addr),
        .all_received (all_received)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = (num_rams_q == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: if (all_received) state_d = ST_DRAIN;
            ST_DRAIN:  if (last_write || drain_timeout) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            num_rams_q     <= '0;
            drain_cnt_q    <= '0;
            swz_resetn     <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            swz_data_valid <= 1'b0;
            swz_data       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_rams_q <= cmd_num_rams;
            end
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + DRAIN_CNT_WIDTH'(1) : '0;
            // Registered from next state so both track the state register with no extra lag.
            swz_resetn  <= (state_d != ST_CLEAR);
            done        <= (state_d == ST_DONE);
            if (resp_spurious || ((state_q == ST_DRAIN) && !last_write && drain_timeout)) begin
                err <= 1'b1;
            end else if (accept) begin
                err <= 1'b0;
            end
            swz_data_valid <= resp_accept;
            if (resp_accept) begin
                swz_data <= rd_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_swizzle_load_ctrl.sv
// Randomized scoreboard bench for swizzle_load_ctrl with memory-controller and swizzle models.
module tb_swizzle_load_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 40;
    localparam int PAW   = 9;
    localparam int WORDS = 512;
    localparam int NRW   = 16;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] addr;
    } req_t;

    typedef struct {
        int unsigned    due;
        logic [NRW-1:0] num;
        logic [PAW-1:0] addr;
    } wr_t;

    logic           clk = 1'b0;
    logic           resetn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_dram_base;
    logic [NRW-1:0] cmd_num_rams;
    logic           rd_req_valid;
    logic           rd_req_ready;
    logic [AW-1:0]  rd_req_addr;
    logic           rd_resp_valid;
    logic [DW-1:0]  rd_resp_data;
    logic           swz_resetn;
    logic           swz_data_valid;
    logic [DW-1:0]  swz_data;
    logic           swz_ram_we;
    logic [PAW-1:0] swz_ram_addr;
    logic [NRW-1:0] swz_ram_num;
    logic           busy;
    logic           done;
    logic           err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [DW-1:0] exp_q[$];
    logic           ready_rand = 1'b0;
    int unsigned    dly_min = 2;
    int unsigned    dly_max = 2;
    logic           hold_resp = 1'b0;
    logic           suppress_final = 1'b0;
    int unsigned    inject_req = 0;
    int unsigned    inject_done = 0;
    logic [NRW-1:0] cur_num = '0;
    logic           legit_drv = 1'b0;
    logic           legit_prev = 1'b0;
    int unsigned    accepts = 0;
    int unsigned    max_in_flight = 0;
    logic [NRW-1:0] last_wr_num = '0;
    logic [PAW-1:0] last_wr_addr = '0;
    int unsigned    swz_rst_cycles = 0;
    int unsigned    req_valid_cycles = 0;
    int unsigned    rst_snap = 0;
    int unsigned    vld_snap = 0;

    always #5 clk = ~clk;

    swizzle_load_ctrl #(
        .DRAM_AWIDTH     (AW),
        .MEM_CTRL_DWIDTH (DW),
        .RAM_PORT_AWIDTH (PAW),
        .RAM_NUM_WORDS   (WORDS),
        .NUM_RAMS_WIDTH  (NRW),
        .MAX_OUTSTANDING (8),
        .DRAIN_TIMEOUT   (255)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dram_base  (cmd_dram_base),
        .cmd_num_rams   (cmd_num_rams),
        .rd_req_valid   (rd_req_valid),
        .rd_req_ready   (rd_req_ready),
        .rd_req_addr    (rd_req_addr),
        .rd_resp_valid  (rd_resp_valid),
        .rd_resp_data   (rd_resp_data),
        .swz_resetn     (swz_resetn),
        .swz_data_valid (swz_data_valid),
        .swz_data       (swz_data),
        .swz_ram_we     (swz_ram_we),
        .swz_ram_addr   (swz_ram_addr),
        .swz_ram_num    (swz_ram_num),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // DRAM contents: unique per address so a wrong read address shows up as wrong data.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'hC3, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory controller: random ready, in-order responses after a bounded delay.
    initial begin
        req_t        r;
        int unsigned cycle;
        int unsigned in_flight;
        logic        prev_stall;
        logic [AW-1:0] prev_addr;
        req_t        pend_q[$];
        cycle = 0; in_flight = 0; prev_stall = 1'b0; prev_addr = '0;
        rd_req_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0;
        forever begin
            @(negedge clk);
            cycle++;
            legit_prev = legit_drv;
            if (!resetn) begin
                pend_q.delete();
                in_flight = 0; prev_stall = 1'b0;
                rd_req_ready = 1'b0; rd_resp_valid = 1'b0;
                legit_drv = 1'b0; legit_prev = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("req_held_valid", rd_req_valid, 1);
                check("req_held_addr", rd_req_addr, prev_addr);
            end
            rd_req_ready = ready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            if (rd_req_valid && rd_req_ready) begin
                r.due  = cycle + $urandom_range(dly_max, dly_min);
                r.addr = rd_req_addr;
                pend_q.push_back(r);
                accepts++;
                in_flight++;
                if (in_flight > max_in_flight) max_in_flight = in_flight;
            end
            prev_stall = rd_req_valid && !rd_req_ready;
            prev_addr  = rd_req_addr;
            legit_drv     = 1'b0;
            rd_resp_valid = 1'b0;
            if (inject_req != inject_done) begin
                rd_resp_valid = 1'b1;
                rd_resp_data  = DW'({$urandom(), $urandom()});
                inject_done++;
            end else if (!hold_resp && pend_q.size() != 0 && pend_q[0].due <= cycle) begin
                r = pend_q.pop_front();
                rd_resp_valid = 1'b1;
                rd_resp_data  = mem_word(r.addr);
                legit_drv     = 1'b1;
                in_flight--;
            end
        end
    end

    // Swizzle model: every forwarded word lands in RAM (beat / WORDS) at (beat % WORDS) a few cycles later.
    initial begin
        wr_t         w;
        wr_t         wr_q[$];
        int unsigned cycle;
        int unsigned beat;
        cycle = 0; beat = 0;
        swz_ram_we = 1'b0; swz_ram_addr = '0; swz_ram_num = '0;
        forever begin
            @(negedge clk);
            cycle++;
            swz_ram_we = 1'b0;
            if (!swz_resetn) begin
                wr_q.delete();
                beat = 0;
                continue;
            end
            if (wr_q.size() != 0 && wr_q[0].due <= cycle) begin
                w = wr_q.pop_front();
                if (!(suppress_final && w.num == cur_num - NRW'(1) && w.addr == PAW'(WORDS - 1))) begin
                    swz_ram_we   = 1'b1;
                    swz_ram_num  = w.num;
                    swz_ram_addr = w.addr;
                    last_wr_num  = w.num;
                    last_wr_addr = w.addr;
                end
            end
            if (swz_data_valid) begin
                w.due  = cycle + 3;
                w.num  = NRW'(beat / WORDS);
                w.addr = PAW'(beat % WORDS);
                wr_q.push_back(w);
                beat++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (!swz_resetn) swz_rst_cycles++;
                if (rd_req_valid) req_valid_cycles++;
            end
        end
    end

    // Monitor: output valid must mirror last cycle's legitimate response; data popped from the scoreboard.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                exp_q.delete();
                continue;
            end
            if (swz_data_valid || legit_prev) begin
                checks++;
                if (swz_data_valid !== legit_prev) begin
                    errors++;
                    $display("FAIL data_valid_latency: got %0b expected %0b", swz_data_valid, legit_prev);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_data: got %0h expected no data", swz_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (swz_data !== exp) begin
                        errors++;
                        $display("FAIL swz_data: got %0h expected %0h", swz_data, exp);
                    end
                end
            end
        end
    end

    task automatic start_cmd(input logic [AW-1:0] base, input logic [NRW-1:0] num);
        int unsigned   n;
        logic [AW-1:0] a;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cur_num = num;
        for (int unsigned i = 0; i < int'(num) * WORDS; i++) begin
            a = base + AW'(i);
            exp_q.push_back(mem_word(a));
        end
        rst_snap      = swz_rst_cycles;
        vld_snap      = req_valid_cycles;
        cmd_dram_base = base;
        cmd_num_rams  = num;
        cmd_valid     = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input logic [NRW-1:0] num, input logic exp_err);
        int unsigned n;
        int unsigned bound;
        n = 0;
        bound = int'(num) * WORDS * 8 + 600;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
        check("err_at_done", err, exp_err);
        check("scoreboard_drained", exp_q.size(), 0);
        if (!exp_err) begin
            check("last_write_ram", last_wr_num, num - NRW'(1));
            check("last_write_addr", last_wr_addr, WORDS - 1);
        end
        check("swz_reset_pulses", swz_rst_cycles - rst_snap, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", cmd_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_req_valid", rd_req_valid, 0);
        check("rst_rd_req_addr", rd_req_addr, 0);
        check("rst_swz_resetn", swz_resetn, 0);
        check("rst_swz_data_valid", swz_data_valid, 0);
        check("rst_swz_data", swz_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    initial begin
        int unsigned n;
        int unsigned acc0;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_dram_base = '0; cmd_num_rams = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        resetn = 1'b1;
        tick();
        check("idle_swz_resetn", swz_resetn, 1);

        // One RAM, fixed 2-cycle latency; stray cmd_valid while busy must be ignored.
        start_cmd(32'h0000_0100, 16'd1);
        check("clear_swz_resetn", swz_resetn, 0);
        check("busy_in_clear", busy, 1);
        cmd_dram_base = 32'hDEAD_0000; cmd_num_rams = 16'd3; cmd_valid = 1'b1;
        tick();
        check("cmd_ready_busy", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        finish_cmd(16'd1, 1'b0);

        // Two RAMs, random backpressure and latency.
        ready_rand = 1'b1; dly_min = 1; dly_max = 4;
        start_cmd(AW'($urandom()), 16'd2);
        finish_cmd(16'd2, 1'b0);
        check("max_outstanding_ok", max_in_flight <= 8, 1);

        // Withheld responses at a base that wraps the address space.
        ready_rand = 1'b0; dly_min = 1; dly_max = 2; hold_resp = 1'b1;
        acc0 = accepts;
        start_cmd(32'hFFFF_FF80, 16'd1);
        repeat (30) tick();
        check("credit_limit_accepts", accepts - acc0, 8);
        check("credit_limit_valid", rd_req_valid, 0);
        hold_resp = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_resp_valid && n < 20);
        check("first_resp_seen", rd_resp_valid, 1);
        check("valid_rerise", rd_req_valid, 1);
        finish_cmd(16'd1, 1'b0);

        // Zero RAMs: CLEAR then DONE, no reads.
        start_cmd(32'h0000_4000, 16'd0);
        check("zero_clear", swz_resetn, 0);
        check("zero_no_done_in_clear", done, 0);
        tick();
        check("zero_done", done, 1);
        check("zero_err", err, 0);
        tick();
        check("zero_done_one_cycle", done, 0);
        check("zero_idle", cmd_ready, 1);
        check("zero_no_requests", req_valid_cycles - vld_snap, 0);

        // Final RAM write never arrives: drain timeout flags err, which stays sticky.
        suppress_final = 1'b1; dly_min = 1; dly_max = 3;
        start_cmd(AW'($urandom()), 16'd1);
        finish_cmd(16'd1, 1'b1);
        suppress_final = 1'b0;
        tick();
        check("err_sticky", err, 1);

        // Spurious response in IDLE, then the next acceptance clears err.
        start_cmd(32'h0001_0000, 16'd1);
        finish_cmd(16'd1, 1'b0);
        inject_req++;
        tick();
        tick();
        check("spurious_err", err, 1);
        check("spurious_not_forwarded", swz_data_valid, 0);
        start_cmd(32'h0002_0000, 16'd1);
        check("err_cleared_on_accept", err, 0);
        finish_cmd(16'd1, 1'b0);

        // Asynchronous reset after 100 accepted reads, then restart at a new base.
        ready_rand = 1'b1;
        acc0 = accepts;
        start_cmd(32'h0003_0000, 16'd1);
        n = 0;
        while (accepts - acc0 < 100 && n < 1000) begin
            tick();
            n++;
        end
        check("reached_100_reads", accepts - acc0 >= 100, 1);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_values();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        start_cmd(32'h0007_0000, 16'd1);
        finish_cmd(16'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
